// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
//  hex_display_pkg
//  Shared 7-segment types and the hex glyph table (active-low {g,f,e,d,c,b,a}).
//  Revision: 1.0
// ============================================================================
package hex_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage : hex_display_pkg
`default_nettype wire

// File: rtl/hex_seg_encoder.sv
`default_nettype none
// ============================================================================
//  hex_seg_encoder
//  Combinational nibble to active-low 7-segment glyph lookup.
//  Revision: 1.0
// ============================================================================
module hex_seg_encoder
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule : hex_seg_encoder
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
//  hex_display_scanner
//  Time-multiplexed common-anode hex display driver with shadow registers,
//  leading-zero suppression, anti-ghost blank slot and frame-done pulse.
//  Revision: 1.0
// ============================================================================
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    enable,
    output seg_t                    seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]   c_idx_last   = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;
    seg_t                    r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_last_digit;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic                    w_zero_sel;
    logic                    w_suppress;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an_lit;
    logic [NUM_DIGITS-1:0]   w_zero_from;
    seg_t                    w_seg;

    assign w_tick       = enable && (r_presc == c_presc_last);
    assign w_last_digit = (r_idx == c_idx_last);

    // w_zero_from[k]: nibbles k..NUM_DIGITS-1 of the shadow value are all zero
    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_zero_from
            assign w_zero_from[k] = ~|r_shadow_val[4*NUM_DIGITS-1:4*k];
        end
    endgenerate

    always_comb begin
        w_nibble   = 4'h0;
        w_dp_sel   = 1'b0;
        w_zero_sel = 1'b0;
        w_an_lit   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble    = r_shadow_val[4*k +: 4];
                w_dp_sel    = r_shadow_dp[k];
                w_zero_sel  = w_zero_from[k];
                w_an_lit[k] = 1'b0;
            end
        end
    end

    // Digit 0 is always shown so an all-zero value still reads "0"
    assign w_suppress = blank_lz && (r_idx != '0) && w_zero_sel;
    assign w_blank    = !enable || w_tick || w_suppress;

    hex_seg_encoder u_seg_encoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_presc      <= '0;
            r_idx        <= '0;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end

            if (enable) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end

            if (w_tick) begin
                r_idx <= w_last_digit ? '0 : r_idx + 1'b1;
            end

            r_frame_done <= w_tick && w_last_digit;

            // The tick cycle is forced dark so the anode switch never ghosts
            if (w_blank) begin
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
                r_an  <= '1;
            end else begin
                r_seg <= w_seg;
                r_dp  <= ~w_dp_sel;
                r_an  <= w_an_lit;
            end
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign an_out     = r_an;
    assign frame_done = r_frame_done;

endmodule : hex_display_scanner
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
//  tb_hex_display_scanner
//  Directed bench with a per-cycle reference model feeding a scoreboard queue.
//  Revision: 1.0
// ============================================================================
module tb_hex_display_scanner;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        enable;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    hex_display_scanner #(
        .NUM_DIGITS (4),
        .CLK_DIV    (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] m_val;
    logic [3:0]  m_dp;
    int          m_idx;
    int          m_presc;

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: predict from pre-edge state, advance model, compare after edge
    task automatic step();
        exp_t e;
        logic tick;
        logic sup;
        tick = enable && (m_presc == 3);
        sup  = blank_lz && (m_idx > 0) && ((m_val >> (4 * m_idx)) == 16'h0);
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fd  = 1'b0;
        if (!Reset) begin
            e.fd = tick && (m_idx == 3);
            if (enable && !tick && !sup) begin
                e.an  = ~(4'b0001 << m_idx);
                e.seg = seg_ref(m_val[4*m_idx +: 4]);
                e.dp  = ~m_dp[m_idx];
            end
        end
        sb_q.push_back(e);
        @(posedge Clk);
        if (Reset) begin
            m_val = '0; m_dp = '0; m_idx = 0; m_presc = 0;
        end else begin
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
            end
            if (enable) m_presc = tick ? 0 : m_presc + 1;
            if (tick)   m_idx   = (m_idx == 3) ? 0 : m_idx + 1;
        end
        #1;
        e = sb_q.pop_front();
        chk("sb_an",  32'(an_out),     32'(e.an));
        chk("sb_seg", 32'(seg_out),    32'(e.seg));
        chk("sb_dp",  32'(dp_out),     32'(e.dp));
        chk("sb_fd",  32'(frame_done), 32'(e.fd));
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d, input logic lz);
        enable   = 1'b0;
        load     = 1'b1;
        value    = v;
        dp_in    = d;
        blank_lz = lz;
        step();
        load     = 1'b0;
        enable   = 1'b1;
    endtask

    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic       exp_dpv [4];

    initial begin
        int lit;
        int good;
        int fd_cnt;
        int last_fd;

        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
        exp_dpv = '{1'b1, 1'b1, 1'b0, 1'b1};

        m_val = '0; m_dp = '0; m_idx = 0; m_presc = 0;
        Reset = 1'b1; value = '0; load = 1'b0; dp_in = '0;
        blank_lz = 1'b0; enable = 1'b0;

        // Reset, then idle with the display disabled
        repeat (3) step();
        Reset = 1'b0;
        repeat (2) begin
            step();
            chk("idle_an", 32'(an_out), 32'hF);
            chk("idle_seg", 32'(seg_out), 32'h7F);
        end

        // Basic scan of 12AF with dp on digit 2
        load_val(16'h12AF, 4'b0100, 1'b0);
        for (int n = 0; n < 16; n++) begin
            step();
            if ((n % 4) == 3) begin
                chk("scan_guard_an", 32'(an_out), 32'hF);
            end else begin
                chk("scan_an",  32'(an_out),  32'(exp_an[n/4]));
                chk("scan_seg", 32'(seg_out), 32'(exp_seg[n/4]));
                chk("scan_dp",  32'(dp_out),  32'(exp_dpv[n/4]));
            end
        end

        // Leading-zero suppression
        load_val(16'h0005, 4'b0000, 1'b1);
        lit = 0; good = 0;
        for (int n = 0; n < 16; n++) begin
            step();
            if (an_out != 4'hF) lit++;
            if (an_out == 4'b1110 && seg_out == 7'b0010010) good++;
        end
        chk("lz5_lit", 32'(lit), 32'd3);
        chk("lz5_seg", 32'(good), 32'd3);

        load_val(16'h0000, 4'b0000, 1'b1);
        lit = 0; good = 0;
        for (int n = 0; n < 16; n++) begin
            step();
            if (an_out != 4'hF) lit++;
            if (an_out == 4'b1110 && seg_out == 7'b1000000) good++;
        end
        chk("lz0_lit", 32'(lit), 32'd3);
        chk("lz0_seg", 32'(good), 32'd3);

        load_val(16'h0105, 4'b1111, 1'b1);
        lit = 0; good = 0;
        for (int n = 0; n < 16; n++) begin
            step();
            if (an_out != 4'hF) lit++;
            if (an_out == 4'b1101 && seg_out == 7'b1000000) good++;
        end
        chk("lz105_lit", 32'(lit), 32'd9);
        chk("lz105_d1", 32'(good), 32'd3);

        // Free run: frame_done cadence
        load_val(16'h12AF, 4'b0000, 1'b0);
        fd_cnt = 0; last_fd = 0;
        for (int n = 1; n <= 64; n++) begin
            step();
            if (frame_done) begin
                fd_cnt++;
                chk("fd_pos", 32'(n - last_fd), 32'd16);
                last_fd = n;
            end
        end
        chk("fd_count", 32'(fd_cnt), 32'd4);

        // Pause in the middle of digit 2
        repeat (10) step();
        enable = 1'b0;
        step();
        chk("pause_an", 32'(an_out), 32'hF);
        repeat (9) step();
        enable = 1'b1;
        step();
        chk("resume_an", 32'(an_out), 32'b1011);
        chk("resume_seg", 32'(seg_out), 32'b0100100);
        step();
        chk("resume_guard", 32'(an_out), 32'hF);
        step();
        chk("resume_d3_an", 32'(an_out), 32'b0111);
        chk("resume_d3_seg", 32'(seg_out), 32'b1111001);

        // Load coinciding with a tick
        for (int n = 0; n < 8 && m_presc != 3; n++) step();
        chk("align_tick", 32'(m_presc), 32'd3);
        value = 16'hEEEE;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("ldtick_guard", 32'(an_out), 32'hF);
        step();
        chk("ldtick_seg", 32'(seg_out), 32'b0000110);

        // Mid-slot reset restarts the scan at digit 0 with a cleared shadow
        step();
        Reset = 1'b1;
        step();
        chk("rst_an", 32'(an_out), 32'hF);
        chk("rst_seg", 32'(seg_out), 32'h7F);
        chk("rst_fd", 32'(frame_done), 32'd0);
        Reset = 1'b0;
        step();
        chk("post_rst_an", 32'(an_out), 32'b1110);
        chk("post_rst_seg", 32'(seg_out), 32'b1000000);
        chk("post_rst_dp", 32'(dp_out), 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hex_display_scanner
`default_nettype wire
